// File: rtl/lsu_pkg.sv
// lsu_pkg: size/state enums and byte-lane helpers shared by the lsu.
// Lanes are little-endian: byte n of a word lives in bits [8n+7:8n].
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    ACC0,
    ACC1
  } state_e;

  // 8-lane mask over two adjacent words; bits [7:4] belong to the next word
  function automatic logic [7:0] lane_mask(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic [7:0] m;
    m = 8'h00;
    unique case (1'b1)
      size == SZ_BYTE: m = 8'h01;
      size == SZ_HALF: m = 8'h03;
      size == SZ_WORD: m = 8'h0f;
      default:         m = 8'h00;
    endcase
    return m << off;
  endfunction

  function automatic logic crosses(
    input logic [1:0] size,
    input logic [1:0] off
  );
    return (size == SZ_WORD && off != 2'b00) ||
           (size == SZ_HALF && off == 2'b11);
  endfunction

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    return (size == SZ_WORD && off != 2'b00) ||
           (size == SZ_HALF && off[0]);
  endfunction

endpackage

// File: rtl/lsu_if.sv
// lsu_if: pipeline request/response plus data-memory port of the lsu.
// master = pipeline and memory side, slave = the lsu itself.
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;

  modport master (
    output req_valid, req_we, req_size,
    output req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    input  dm_we, dm_addr, dm_wdata,
    output dm_rdata
  );

  modport slave (
    input  req_valid, req_we, req_size,
    input  req_unsigned, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    output dm_we, dm_addr, dm_wdata,
    input  dm_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: lane select, store merge and load extension (pure comb).
// hi selects the second word of a two-word access.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [1:0]  off,
  input  logic        hi,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  input  logic [63:0] ldata,
  output logic [3:0]  lanes,
  output logic [31:0] mdata,
  output logic [31:0] ldout
);

  logic [7:0]  mask;
  logic [63:0] wsh;
  logic [31:0] wsel;
  logic [31:0] lw;

  always_comb begin
    mask  = lane_mask(size, off);
    lanes = hi ? mask[7:4] : mask[3:0];
    wsh   = {32'h0, wdata} << {off, 3'b000};
    wsel  = hi ? wsh[63:32] : wsh[31:0];
    mdata = rdata;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) mdata[8*i +: 8] = wsel[8*i +: 8];
    end
    lw    = 32'(ldata >> {off, 3'b000});
    ldout = lw;
    unique case (1'b1)
      size == SZ_BYTE: ldout = {{24{~uns & lw[7]}}, lw[7:0]};
      size == SZ_HALF: ldout = {{16{~uns & lw[15]}}, lw[15:0]};
      default:         ldout = lw;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: byte/half/word load-store unit with read-modify-write stores.
// Define LSU_MISALIGN_EN to split word-crossing accesses over two words.
module lsu
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input logic clk,
  input logic rst,
  lsu_if.slave bus
);

  localparam int AW = $clog2(MEM_WORDS);

  state_e        state, state_n;
  logic          r_we, r_uns;
  logic [1:0]    r_size;
  logic [31:0]   r_addr, r_wdata;
  logic          accept, bad, done, hi, acc;
  logic [AW-1:0] idx0, idx;
  logic [3:0]    lanes;
  logic [31:0]   mdata, ldout;
  logic [63:0]   ldata;
  logic          unused;

  // one request in flight until its response has been seen
  assign bus.req_ready = state == IDLE && !bus.resp_valid && !rst;
  assign accept = bus.req_valid && bus.req_ready;
  assign acc    = state != IDLE;
  assign idx0   = r_addr[AW+1:2];
  assign unused = ^r_addr[31:AW+2];

`ifdef LSU_MISALIGN_EN
  logic        cross;
  logic [31:0] lo_q;

  assign bad   = bus.req_size == 2'b11;
  assign cross = crosses(r_size, r_addr[1:0]);
  assign hi    = state == ACC1;
  assign idx   = hi ? idx0 + AW'(1) : idx0;
  assign ldata = hi ? {bus.dm_rdata, lo_q}
                    : {32'h0, bus.dm_rdata};
`else
  assign bad   = bus.req_size == 2'b11 ||
                 misaligned(bus.req_size, bus.req_addr[1:0]);
  assign hi    = 1'b0;
  assign idx   = idx0;
  assign ldata = {32'h0, bus.dm_rdata};
`endif

  assign bus.dm_addr  = 32'(idx);
  assign bus.dm_we    = acc && r_we && |lanes && !rst;
  assign bus.dm_wdata = mdata;

  lsu_align u_align (
    .size  (r_size),
    .uns   (r_uns),
    .off   (r_addr[1:0]),
    .hi    (hi),
    .wdata (r_wdata),
    .rdata (bus.dm_rdata),
    .ldata (ldata),
    .lanes (lanes),
    .mdata (mdata),
    .ldout (ldout)
  );

  always_comb begin
    state_n = state;
    done    = 1'b0;
    unique case (state)
      IDLE: if (accept && !bad) state_n = ACC0;
      ACC0: begin
`ifdef LSU_MISALIGN_EN
        state_n = cross ? ACC1 : IDLE;
        done    = !cross;
`else
        state_n = IDLE;
        done    = 1'b1;
`endif
      end
`ifdef LSU_MISALIGN_EN
      ACC1: begin
        state_n = IDLE;
        done    = 1'b1;
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      r_we           <= 1'b0;
      r_uns          <= 1'b0;
      r_size         <= 2'b00;
      r_addr         <= 32'h0;
      r_wdata        <= 32'h0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= 32'h0;
      bus.resp_err   <= 1'b0;
`ifdef LSU_MISALIGN_EN
      lo_q           <= 32'h0;
`endif
    end else begin
      state          <= state_n;
      bus.resp_valid <= 1'b0;
      if (accept) begin
        r_we    <= bus.req_we;
        r_uns   <= bus.req_unsigned;
        r_size  <= bus.req_size;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        if (bad) begin
          bus.resp_valid <= 1'b1;
          bus.resp_err   <= 1'b1;
          bus.resp_rdata <= 32'h0;
        end
      end
`ifdef LSU_MISALIGN_EN
      if (state == ACC0) lo_q <= bus.dm_rdata;
`endif
      if (done) begin
        bus.resp_valid <= 1'b1;
        bus.resp_err   <= 1'b0;
        bus.resp_rdata <= r_we ? 32'h0 : ldout;
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: table-driven lsu bench with a response scoreboard.
// Expected values follow LSU_MISALIGN_EN when it is defined.
module tb_lsu;

  localparam int MW = 64;
  localparam int AW = 6;
  localparam int NV = 18;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nwr;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_if bus();

  lsu #(.MEM_WORDS(MW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [MW];
  int   cyc = 0;
  int   nwr = 0;
  int   nresp = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];
  vec_t tv[NV];

  assign bus.dm_rdata = mem[bus.dm_addr[AW-1:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.dm_we === 1'b1) begin
      mem[bus.dm_addr[AW-1:0]] <= bus.dm_wdata;
      nwr <= nwr + 1;
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst === 1'b0 && bus.resp_valid === 1'b1) begin
      nresp++;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL resp_unexpected: got resp_valid=1 expected 0");
      end else begin
        e = sb.pop_front();
        chk("resp_rdata", bus.resp_rdata, e.rdata);
        chk("resp_err", 32'(bus.resp_err), 32'(e.err));
        chk("resp_latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk("req_ready_wait", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic issue(input vec_t v);
    wait_ready();
    bus.req_we       = v.we;
    bus.req_size     = v.size;
    bus.req_unsigned = v.uns;
    bus.req_addr     = v.addr;
    bus.req_wdata    = v.wdata;
    bus.req_valid    = 1'b1;
    sb.push_back('{v.rdata, v.err, cyc + v.lat});
    @(negedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 10) begin
      @(negedge clk); #1;
      n++;
    end
    chk("resp_drain", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    int   w0;
    int   r0;
    vec_t v;
    logic [7:0] pat;

    rst = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    for (int i = 0; i < MW; i++) mem[i] <= 32'h0;
    mem[3] <= 32'h8899AABB;
    mem[4] <= 32'h44332211;
    mem[5] <= 32'h88776655;

    tv[0]  = '{0, 2'd0, 0, 32'h0D, 32'h0, 32'hFFFFFFAA, 0, 2, 0};
    tv[1]  = '{0, 2'd0, 1, 32'h0D, 32'h0, 32'h000000AA, 0, 2, 0};
    tv[2]  = '{0, 2'd1, 0, 32'h0E, 32'h0, 32'hFFFF8899, 0, 2, 0};
    tv[3]  = '{0, 2'd1, 1, 32'h0C, 32'h0, 32'h0000AABB, 0, 2, 0};
    tv[4]  = '{0, 2'd2, 0, 32'h10, 32'h0, 32'h44332211, 0, 2, 0};
    tv[5]  = '{0, 2'd0, 0, 32'h13, 32'h0, 32'h00000044, 0, 2, 0};
    tv[6]  = '{0, 2'd0, 0, 32'h17, 32'h0, 32'hFFFFFF88, 0, 2, 0};
`ifdef LSU_MISALIGN_EN
    tv[7]  = '{0, 2'd2, 0, 32'h12, 32'h0, 32'h66554433, 0, 3, 0};
    tv[8]  = '{0, 2'd1, 0, 32'h13, 32'h0, 32'h00005544, 0, 3, 0};
    tv[9]  = '{0, 2'd1, 1, 32'h11, 32'h0, 32'h00003322, 0, 2, 0};
`else
    tv[7]  = '{0, 2'd2, 0, 32'h12, 32'h0, 32'h0, 1, 1, 0};
    tv[8]  = '{0, 2'd1, 0, 32'h13, 32'h0, 32'h0, 1, 1, 0};
    tv[9]  = '{0, 2'd1, 1, 32'h11, 32'h0, 32'h0, 1, 1, 0};
`endif
    tv[10] = '{0, 2'd3, 0, 32'h10, 32'h0, 32'h0, 1, 1, 0};
    tv[11] = '{1, 2'd0, 0, 32'h09, 32'h123456A5, 32'h0, 0, 2, 1};
    tv[12] = '{0, 2'd2, 0, 32'h08, 32'h0, 32'h0000A500, 0, 2, 0};
    tv[13] = '{1, 2'd1, 0, 32'h0E, 32'hFFFF1234, 32'h0, 0, 2, 1};
    tv[14] = '{0, 2'd2, 0, 32'h0C, 32'h0, 32'h1234AABB, 0, 2, 0};
`ifdef LSU_MISALIGN_EN
    tv[15] = '{1, 2'd2, 0, 32'h1A, 32'hA1B2C3D4, 32'h0, 0, 3, 2};
    tv[16] = '{0, 2'd2, 0, 32'h18, 32'h0, 32'hC3D40000, 0, 2, 0};
    tv[17] = '{0, 2'd2, 0, 32'h1C, 32'h0, 32'h0000A1B2, 0, 2, 0};
`else
    tv[15] = '{1, 2'd2, 0, 32'h1A, 32'hA1B2C3D4, 32'h0, 1, 1, 0};
    tv[16] = '{0, 2'd2, 0, 32'h18, 32'h0, 32'h0, 0, 2, 0};
    tv[17] = '{0, 2'd2, 0, 32'h1C, 32'h0, 32'h0, 0, 2, 0};
`endif

    repeat (3) @(negedge clk);
    #1;
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_dm_we", 32'(bus.dm_we), 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(bus.req_ready), 32'd1);

    for (int i = 0; i < NV; i++) begin
      w0 = nwr;
      issue(tv[i]);
      wait_drain();
      chk($sformatf("dm_we_count[%0d]", i), 32'(nwr - w0), 32'(tv[i].nwr));
    end
    chk("mem_word3", mem[3], 32'h1234AABB);

    // store word at the last byte of memory wraps to word 0
    mem[MW-1] <= 32'h11223344;
    mem[0]    <= 32'h55667788;
    #1;
    w0 = nwr;
`ifdef LSU_MISALIGN_EN
    v = '{1, 2'd2, 0, 32'(4*MW-1), 32'hDEADBEEF, 32'h0, 0, 3, 2};
`else
    v = '{1, 2'd2, 0, 32'(4*MW-1), 32'hDEADBEEF, 32'h0, 1, 1, 0};
`endif
    issue(v);
    wait_drain();
    chk("wrap_dm_we_count", 32'(nwr - w0), 32'(v.nwr));
`ifdef LSU_MISALIGN_EN
    chk("wrap_mem_last", mem[MW-1], 32'hEF223344);
    chk("wrap_mem_0", mem[0], 32'h55DEADBE);
`else
    chk("wrap_mem_last", mem[MW-1], 32'h11223344);
    chk("wrap_mem_0", mem[0], 32'h55667788);
`endif

    // reset during ACC0 of a store kills the write and the response
    mem[8] <= 32'h12345678;
    wait_ready();
    w0 = nwr;
    r0 = nresp;
    bus.req_we       = 1'b1;
    bus.req_size     = 2'd2;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h20;
    bus.req_wdata    = 32'hCAFEF00D;
    bus.req_valid    = 1'b1;
    @(negedge clk); #1;
    bus.req_valid = 1'b0;
    chk("acc0_dm_we", 32'(bus.dm_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_gates_dm_we", 32'(bus.dm_we), 32'd0);
    @(negedge clk); #1;
    chk("rst_holds_ready_low", 32'(bus.req_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst_fall", 32'(bus.req_ready), 32'd1);
    repeat (4) begin
      @(negedge clk); #1;
    end
    chk("rst_mem_unchanged", mem[8], 32'h12345678);
    chk("rst_no_write", 32'(nwr - w0), 32'd0);
    chk("rst_no_resp", 32'(nresp - r0), 32'd0);

    // illegal-size stores held back to back
    wait_ready();
    w0  = nwr;
    pat = 8'h00;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'b11;
    bus.req_addr  = 32'h24;
    bus.req_wdata = 32'hFFFFFFFF;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (bus.req_ready === 1'b1) begin
        pat[i] = 1'b1;
        sb.push_back('{32'h0, 1'b1, cyc + 1});
      end
      @(negedge clk); #1;
    end
    bus.req_valid = 1'b0;
    wait_drain();
    chk("b2b_accept_pattern", 32'(pat), 32'h55);
    chk("b2b_no_write", 32'(nwr - w0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, meaning data-memory depth in 32-bit words (power of two).
REQ-002 SHALL have port clk  input  1  core clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  pipeline presents a memory request.
REQ-005 SHALL have port req_ready  output  1  high when the block can accept a request.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 SHALL have port req_unsigned  input  1  zero-extend load result when 1, sign-extend when 0.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata  output  32  extended load data.
REQ-013 SHALL have port resp_err  output  1  request rejected, no memory side effect.
REQ-014 SHALL have port dm_we  output  1  data-memory write enable.
REQ-015 SHALL have port dm_addr  output  32  data-memory word index.
REQ-016 SHALL have port dm_wdata  output  32  data-memory write word.
REQ-017 SHALL have port dm_rdata  input  32  data-memory combinational read word.

Function
REQ-018 SHALL use the states IDLE, ACC0 and ACC1, with little-endian byte lanes.
REQ-019 SHALL assert req_ready only in IDLE; req_valid&&req_ready registers the request and moves the FSM to ACC0.
REQ-020 SHALL drive dm_addr = (req_addr>>2) mod MEM_WORDS in ACC0 and ((req_addr>>2)+1) mod MEM_WORDS in ACC1, so the last word wraps to index 0.
REQ-021 SHALL perform stores as a read-modify-write within a single cycle: merge the enabled lanes of req_wdata into dm_rdata, drive dm_wdata, and assert dm_we in that cycle.
REQ-022 SHALL assert dm_we only for the lanes that fall in the current word, and never in IDLE.
REQ-023 SHALL treat an access as crossing when the size is word with addr[1:0]!=0, or half with addr[1:0]==3.
REQ-024 SHALL go ACC0->ACC1 for a crossing access and ACC0->IDLE otherwise, and ACC1->IDLE always.
REQ-025 SHALL capture load bytes from dm_rdata in each ACC cycle, then assemble and extend them per req_size/req_unsigned.
REQ-026 SHALL pulse resp_valid for exactly one cycle after the final ACC cycle (the FSM is then IDLE), giving latency 2 cycles non-crossing and 3 cycles crossing from the accept edge.
REQ-027 SHALL register resp_rdata, hold it until the next resp_valid, and return 0 for stores.
REQ-028 SHALL, for req_size==11, go directly to IDLE, make no dmem access, and produce resp_valid=1 with resp_err=1 one cycle after accept.

Reset
REQ-029 SHALL, with rst high at a clock edge, force state IDLE and resp_valid=0, resp_rdata=0, resp_err=0 and clear all request registers.
REQ-030 SHALL gate dm_we with !rst so that a reset asserted during ACC0 or ACC1 suppresses that cycle's write; a partially completed crossing store is not rolled back.
REQ-031 SHALL keep req_ready=0 while rst is high.

Configuration
REQ-032 SHALL use the macro LSU_MISALIGN_EN: when defined, crossing accesses are split per REQ-024 and resp_err is only set by REQ-028.
REQ-033 SHALL, without LSU_MISALIGN_EN, reject every non-natural alignment (word addr[1:0]!=0, half addr[0]==1) like REQ-028 (no write, resp_err=1, resp_rdata=0), and contain no ACC1 logic.

Structure
REQ-034 SHALL take from a shared package lsu_pkg the size enum (SZ_BYTE, SZ_HALF, SZ_WORD), the state enum and the lane-mask function.
REQ-035 SHALL put lane extract, merge and sign-extension in a combinational sub-module lsu_align, instantiated once.

Verification
REQ-036 SHALL cover: word[3]=0x8899AABB, then load byte signed at 0x0D -> resp_rdata=0xFFFFFFAA 2 cycles after accept, dm_we never high.
REQ-037 SHALL cover: store half 0x1234 at 0x0E onto word[3]=0x8899AABB -> word[3]=0x1234AABB, single dm_we pulse.
REQ-038 SHALL cover, with LSU_MISALIGN_EN: word[4]=0x44332211, word[5]=0x88776655, then load word at 0x12 -> 0x66554433, latency 3; without the macro the same load gives resp_err=1 and resp_rdata=0.
REQ-039 SHALL cover, with LSU_MISALIGN_EN: store word 0xDEADBEEF at byte 4*MEM_WORDS-1 -> word[MEM_WORDS-1][31:24]=0xEF, word[0][23:0]=0xDEADBE.
REQ-040 SHALL cover: rst raised in ACC0 of a store -> memory unchanged, resp_valid stays 0, req_ready=1 the first cycle after rst falls.
REQ-041 SHALL cover: req_size=11 with req_we=1 -> resp_err=1 one cycle after accept, no dm_we, and back-to-back requests accepted every 2 cycles.
